// File: rtl/tinycpu_pkg.sv
// Shared tinycpu definitions: SRAM responder state type and default bus geometry.
package tinycpu_pkg;

    localparam int TINYCPU_AW    = 8;
    localparam int TINYCPU_DW    = 8;
    localparam int TINYCPU_DEPTH = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } sram_state_e;

endpackage

// File: rtl/sram_resp_check.sv
// Sticky protocol checker for the tinycpu SRAM bus: flags contention, a write
// address that moves mid-write, and wen asserted without cen.
module sram_resp_check
    import tinycpu_pkg::*;
#(
    parameter int AW = TINYCPU_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    input  logic          cen,
    input  logic          wen,
    input  logic          oen,
    input  sram_state_e   state,
    output logic          err
);

    logic [AW-1:0] addr_q;
    logic          err_q;
    logic          err_d;
    logic          violation;

    // addr_q holds the address sampled at the previous edge, which is the
    // address of the write in progress whenever state is WR.
    always_comb begin
        violation = 1'b0;
        if (!cen && !wen && !oen) begin
            violation = 1'b1;
        end
        if (cen && !wen) begin
            violation = 1'b1;
        end
        if ((state == WR) && !cen && !wen && (addr != addr_q)) begin
            violation = 1'b1;
        end
        err_d = err_q | violation;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            err_q  <= err_d;
            addr_q <= addr;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/sram_resp.sv
// SRAM responder for the tinycpu bus: array, access FSM, saturating counters and
// dq tristate. Define SRAM_RESP_CHECK_EN to build the sticky protocol checker.
module sram_resp
    import tinycpu_pkg::*;
#(
    parameter int AW    = TINYCPU_AW,
    parameter int DW    = TINYCPU_DW,
    parameter int DEPTH = TINYCPU_DEPTH,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    input  logic          cen,
    input  logic          wen,
    input  logic          oen,
    inout  wire  [DW-1:0] dq,
    output logic [CW-1:0] rd_cnt,
    output logic [CW-1:0] wr_cnt,
    output logic          err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [IW-1:0] memIdx;
    logic          rdReq;
    logic          rdEn;
    logic          wrEn;
    logic          rdInc;
    logic          wrInc;

    sram_state_e   state_q;
    sram_state_e   state_d;
    logic [CW-1:0] rdCnt_q;
    logic [CW-1:0] rdCnt_d;
    logic [CW-1:0] wrCnt_q;
    logic [CW-1:0] wrCnt_d;

    function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + CW'(1) : v;
    endfunction

    // Out-of-range addresses alias modulo DEPTH.
    assign memIdx = IW'(32'(addr) % 32'(DEPTH));
    assign rdReq  = !cen && !oen && wen;
    assign wrEn   = !cen && !wen;
    assign rdEn   = rdReq && reset;

    assign dq = rdEn ? mem[memIdx] : 'z;

    // Writes sampled while reset is held are dropped; contents survive reset.
    always_ff @(posedge clk or negedge reset) begin
        if (reset && wrEn) begin
            mem[memIdx] <= dq;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rdCnt_q <= '0;
            wrCnt_q <= '0;
        end else begin
            state_q <= state_d;
            rdCnt_q <= rdCnt_d;
            wrCnt_q <= wrCnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (wrEn)       state_d = WR;
                else if (rdReq) state_d = RD;
            end
            RD: begin
                if (wrEn)       state_d = WR;
                else if (rdReq) state_d = RD;
                else if (cen)   state_d = IDLE;
            end
            WR: begin
                if (wrEn)       state_d = WR;
                else if (cen)   state_d = IDLE;
                else if (rdReq) state_d = RD;
            end
            default:            state_d = IDLE;
        endcase
    end

    // A read is counted when it leaves RD; a write only when it enters WR.
    always_comb begin
        rdInc   = (state_q == RD) && (wrEn || cen);
        wrInc   = wrEn && (state_q != WR);
        rdCnt_d = satInc(rdCnt_q, rdInc);
        wrCnt_d = satInc(wrCnt_q, wrInc);
    end

    assign rd_cnt = rdCnt_q;
    assign wr_cnt = wrCnt_q;

`ifdef SRAM_RESP_CHECK_EN
    sram_resp_check #(
        .AW(AW)
    ) uCheck (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .cen  (cen),
        .wen  (wen),
        .oen  (oen),
        .state(state_q),
        .err  (err)
    );
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_resp.sv
// Bench for sram_resp: two instances (default geometry, and DEPTH=16/CW=2) share
// one stimulus stream and are compared each cycle against a transaction model.
module tb_sram_resp;

    logic       clk = 1'b0;
    logic       resetN;
    logic [7:0] addr;
    logic       cen;
    logic       wen;
    logic       oen;
    logic [7:0] tbData;
    logic       tbDrive;
    wire  [7:0] dqA;
    wire  [7:0] dqB;
    logic [15:0] rdCntA;
    logic [15:0] wrCntA;
    logic [1:0]  rdCntB;
    logic [1:0]  wrCntB;
    logic        errA;
    logic        errB;

    int  errors = 0;
    int  checks = 0;
    bit  checking = 1'b0;
    int  expRd = 0;
    int  expWr = 0;
    int  expErr = 0;
    int  checkEn;

    logic [7:0] memA [256];
    bit         validA [256];
    logic [7:0] memB [16];
    bit         validB [16];

    assign dqA = tbDrive ? tbData : 8'hzz;
    assign dqB = tbDrive ? tbData : 8'hzz;

    always #5 clk = ~clk;

    sram_resp #(.AW(8), .DW(8), .DEPTH(256), .CW(16)) dutA (
        .clk(clk), .reset(resetN), .addr(addr), .cen(cen), .wen(wen), .oen(oen),
        .dq(dqA), .rd_cnt(rdCntA), .wr_cnt(wrCntA), .err(errA)
    );

    sram_resp #(.AW(8), .DW(8), .DEPTH(16), .CW(2)) dutB (
        .clk(clk), .reset(resetN), .addr(addr), .cen(cen), .wen(wen), .oen(oen),
        .dq(dqB), .rd_cnt(rdCntB), .wr_cnt(wrCntB), .err(errB)
    );

    function automatic int sat(input int v, input int maxV);
        return (v > maxV) ? maxV : v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Array model: any sampled write outside reset stores the driven data.
    always @(posedge clk) begin
        if (resetN && !cen && !wen) begin
            memA[addr]        = tbData;
            validA[addr]      = 1'b1;
            memB[addr % 16]   = tbData;
            validB[addr % 16] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("rdCntA", 32'(rdCntA), 32'(sat(expRd, 65535)));
            checkOutput("wrCntA", 32'(wrCntA), 32'(sat(expWr, 65535)));
            checkOutput("rdCntB", 32'(rdCntB), 32'(sat(expRd, 3)));
            checkOutput("wrCntB", 32'(wrCntB), 32'(sat(expWr, 3)));
            checkOutput("errA", 32'(errA), 32'(expErr));
            checkOutput("errB", 32'(errB), 32'(expErr));
            if (resetN && !cen && !oen && wen) begin
                if (validA[addr]) checkOutput("dqA", 32'(dqA), 32'(memA[addr]));
                if (validB[addr % 16]) checkOutput("dqB", 32'(dqB), 32'(memB[addr % 16]));
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] a, input logic c, input logic w,
                                 input logic o, input logic drv, input logic [7:0] d);
        addr = a; cen = c; wen = w; oen = o; tbDrive = drv; tbData = d;
    endtask

    task automatic doWrite(input logic [7:0] a, input logic [7:0] d);
        applyStimulus(a, 1'b0, 1'b0, 1'b1, 1'b1, d);
        step();
        expWr++;
        applyStimulus(a, 1'b1, 1'b1, 1'b1, 1'b0, d);
        step();
    endtask

    task automatic doRead(input logic [7:0] a, input int litA, input int litB);
        applyStimulus(a, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        #1;
        if (litA >= 0) checkOutput("readLitA", 32'(dqA), 32'(litA));
        if (litB >= 0) checkOutput("readLitB", 32'(dqB), 32'(litB));
        step();
        applyStimulus(a, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        step();
        expRd++;
    endtask

    initial begin
`ifdef SRAM_RESP_CHECK_EN
        checkEn = 1;
`else
        checkEn = 0;
`endif
        resetN = 1'b0;
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        repeat (2) step();
        checkOutput("resetRdCnt", 32'(rdCntA), 32'd0);
        checkOutput("resetWrCnt", 32'(wrCntA), 32'd0);
        checkOutput("resetErr", 32'(errA), 32'd0);
        resetN = 1'b1;
        checking = 1'b1;
        step();

        // Known value at 0x12, then a write cut short by reset.
        doWrite(8'h12, 8'h5A);
        applyStimulus(8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 8'h99);
        #1;
        resetN = 1'b0;
        expRd = 0; expWr = 0; expErr = 0;
        step();
        checkOutput("midResetWrCnt", 32'(wrCntA), 32'd0);
        checkOutput("midResetErr", 32'(errA), 32'd0);
        applyStimulus(8'h12, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        resetN = 1'b1;
        step();
        doRead(8'h12, 'h5A, 'h5A);
        checkOutput("rdAfterReset", 32'(rdCntA), 32'd1);

        doWrite(8'h12, 8'hA5);
        doRead(8'h12, 'hA5, 'hA5);
        checkOutput("wrCntAfterA5", 32'(wrCntA), 32'd1);
        checkOutput("rdCntAfterA5", 32'(rdCntA), 32'd2);

        for (int i = 0; i < 4; i++) doWrite(8'(i), 8'(8'h40 + i));
        for (int i = 0; i < 4; i++) doRead(8'(i), 'h40 + i, 'h40 + i);
        checkOutput("rdCntA6", 32'(rdCntA), 32'd6);
        checkOutput("wrCntA5", 32'(wrCntA), 32'd5);
        checkOutput("wrCntBSat", 32'(wrCntB), 32'd3);
        checkOutput("rdCntBSat", 32'(rdCntB), 32'd3);

        doWrite(8'h15, 8'h77);
        doRead(8'h05, -1, 'h77);

        // Read that turns straight into a write: counted by both counters.
        applyStimulus(8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        #1;
        checkOutput("rdToWrLitA", 32'(dqA), 32'hA5);
        checkOutput("rdToWrLitB", 32'(dqB), 32'h42);
        step();
        applyStimulus(8'h30, 1'b0, 1'b0, 1'b1, 1'b1, 8'h81);
        step();
        expRd++; expWr++;
        checkOutput("rdToWrRd", 32'(rdCntA), 32'd8);
        checkOutput("rdToWrWr", 32'(wrCntA), 32'd7);
        applyStimulus(8'h30, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        step();

        // Contention: write commits, err depends on the checker build.
        applyStimulus(8'h20, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C);
        step();
        expWr++;
        expErr = checkEn;
        applyStimulus(8'h20, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        step();
        checkOutput("contentionErr", 32'(errA), 32'(checkEn));
        doRead(8'h20, 'h3C, 'h3C);
        doRead(8'h30, 'h81, 'h3C);
        repeat (3) step();

        checkOutput("finalRdA", 32'(rdCntA), 32'd10);
        checkOutput("finalWrA", 32'(wrCntA), 32'd8);
        checkOutput("finalErrB", 32'(errB), 32'(checkEn));
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
